// File: rtl/adc_capture_ctrl_if.sv
// ADC parallel-bus pins: conversion start, busy handshake, chip select, read strobe, data.
interface adc_capture_ctrl_if;
    localparam int unsigned DB_W = 14;

    logic            ADC_O_convst_n;
    logic            ADC_I_busy;
    logic            ADC_O_cs_n;
    logic            ADC_O_rd_n;
    logic [DB_W-1:0] ADC_I_db;

    // Controller side drives the strobes and samples busy/data.
    modport master (
        output ADC_O_convst_n,
        output ADC_O_cs_n,
        output ADC_O_rd_n,
        input  ADC_I_busy,
        input  ADC_I_db
    );

    // ADC (or its model) side.
    modport slave (
        input  ADC_O_convst_n,
        input  ADC_O_cs_n,
        input  ADC_O_rd_n,
        output ADC_I_busy,
        output ADC_I_db
    );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Paces a simultaneous-sampling parallel ADC: periodic convst, busy handshake,
// then sequential channel reads emitted as tagged one-cycle data strobes.
module adc_capture_ctrl #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned SAMPLE_DIV   = 400,
    parameter int unsigned CONVST_LEN   = 2,
    parameter int unsigned RD_LOW       = 3,
    parameter int unsigned RD_GAP       = 2,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic               ADC_I_clk,
    input  logic               I_rst_n,
    input  logic               I_enable,
    adc_capture_ctrl_if.master adc,
    output logic               O_dataValid,
    output logic [15:0]        O_data,
    output logic               O_overrun,
    output logic               O_timeout,
    output logic               O_frameDone
);
    localparam int unsigned CH_W     = 2;
    localparam int unsigned TICK_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned PH_MAX_A = (CONVST_LEN > RD_LOW) ? CONVST_LEN : RD_LOW;
    localparam int unsigned PH_MAX   = (PH_MAX_A > RD_GAP) ? PH_MAX_A : RD_GAP;
    localparam int unsigned PH_W     = $clog2(PH_MAX + 1);
    localparam int unsigned TMO_W    = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVST,
        ST_WAIT_BHI,
        ST_WAIT_BLO,
        ST_RD_LO,
        ST_RD_HI
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic [PH_W-1:0]   ph_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [CH_W-1:0]   ch;
    logic              busy_meta;
    logic              busy_sync;
    logic              tick_c;
    logic              tmo_expired_c;

    assign tick_c        = I_enable && (tick_cnt == TICK_W'(SAMPLE_DIV - 1));
    assign tmo_expired_c = (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1));

    // Two-flop synchronizer for the asynchronous busy pin.
    always_ff @(posedge ADC_I_clk) begin
        if (!I_rst_n) begin
            busy_meta <= 1'b0;
            busy_sync <= 1'b0;
        end else begin
            busy_meta <= adc.ADC_I_busy;
            busy_sync <= busy_meta;
        end
    end

    // Sample-period counter; parked at zero while sampling is disabled.
    always_ff @(posedge ADC_I_clk) begin
        if (!I_rst_n) begin
            tick_cnt <= '0;
        end else if (!I_enable || tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Conversion/read sequencer with registered ADC strobes and result outputs.
    always_ff @(posedge ADC_I_clk) begin
        if (!I_rst_n) begin
            state              <= ST_IDLE;
            ph_cnt             <= '0;
            tmo_cnt            <= '0;
            ch                 <= '0;
            adc.ADC_O_convst_n <= 1'b1;
            adc.ADC_O_cs_n     <= 1'b1;
            adc.ADC_O_rd_n     <= 1'b1;
            O_dataValid        <= 1'b0;
            O_data             <= '0;
            O_overrun          <= 1'b0;
            O_timeout          <= 1'b0;
            O_frameDone        <= 1'b0;
        end else begin
            O_dataValid <= 1'b0;
            O_frameDone <= 1'b0;

            // A tick can only start a frame from IDLE; anywhere else it is lost.
            if (tick_c && (state != ST_IDLE)) begin
                O_overrun <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (tick_c) begin
                        ph_cnt             <= '0;
                        adc.ADC_O_convst_n <= 1'b0;
                        state              <= ST_CONVST;
                    end
                end
                ST_CONVST: begin
                    if (ph_cnt == PH_W'(CONVST_LEN - 1)) begin
                        adc.ADC_O_convst_n <= 1'b1;
                        tmo_cnt            <= '0;
                        state              <= ST_WAIT_BHI;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                ST_WAIT_BHI: begin
                    if (busy_sync) begin
                        tmo_cnt <= '0;
                        state   <= ST_WAIT_BLO;
                    end else if (tmo_expired_c) begin
                        O_timeout          <= 1'b1;
                        adc.ADC_O_convst_n <= 1'b1;
                        adc.ADC_O_cs_n     <= 1'b1;
                        adc.ADC_O_rd_n     <= 1'b1;
                        state              <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_WAIT_BLO: begin
                    if (!busy_sync) begin
                        adc.ADC_O_cs_n <= 1'b0;
                        adc.ADC_O_rd_n <= 1'b0;
                        ch             <= '0;
                        ph_cnt         <= '0;
                        state          <= ST_RD_LO;
                    end else if (tmo_expired_c) begin
                        O_timeout          <= 1'b1;
                        adc.ADC_O_convst_n <= 1'b1;
                        adc.ADC_O_cs_n     <= 1'b1;
                        adc.ADC_O_rd_n     <= 1'b1;
                        state              <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_RD_LO: begin
                    // Data bus is sampled at the end of the last rd_n-low cycle.
                    if (ph_cnt == PH_W'(RD_LOW - 1)) begin
                        adc.ADC_O_rd_n <= 1'b1;
                        O_dataValid    <= 1'b1;
                        O_data         <= {ch, adc.ADC_I_db};
                        ph_cnt         <= '0;
                        state          <= ST_RD_HI;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                ST_RD_HI: begin
                    if (ph_cnt == PH_W'(RD_GAP - 1)) begin
                        ph_cnt <= '0;
                        if (ch != CH_W'(NUM_CH - 1)) begin
                            ch             <= ch + CH_W'(1);
                            adc.ADC_O_rd_n <= 1'b0;
                            state          <= ST_RD_LO;
                        end else begin
                            adc.ADC_O_cs_n <= 1'b1;
                            O_frameDone    <= 1'b1;
                            state          <= ST_IDLE;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: behavioural ADC models, scoreboard queues, protocol monitors.
module tb_adc_capture_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_a;
    logic        en_b;
    logic        dv_a, ovr_a, tmo_a, fd_a;
    logic [15:0] data_a;
    logic        dv_b, ovr_b, tmo_b, fd_b;
    logic [15:0] data_b;

    adc_capture_ctrl_if if_a ();
    adc_capture_ctrl_if if_b ();

    adc_capture_ctrl #(.NUM_CH(4), .SAMPLE_DIV(400), .CONVST_LEN(2), .RD_LOW(3),
                       .RD_GAP(2), .BUSY_TIMEOUT(64)) dut_a (
        .ADC_I_clk   (clk),
        .I_rst_n     (rst_n),
        .I_enable    (en_a),
        .adc         (if_a),
        .O_dataValid (dv_a),
        .O_data      (data_a),
        .O_overrun   (ovr_a),
        .O_timeout   (tmo_a),
        .O_frameDone (fd_a)
    );

    adc_capture_ctrl #(.NUM_CH(4), .SAMPLE_DIV(30), .CONVST_LEN(2), .RD_LOW(3),
                       .RD_GAP(2), .BUSY_TIMEOUT(64)) dut_b (
        .ADC_I_clk   (clk),
        .I_rst_n     (rst_n),
        .I_enable    (en_b),
        .adc         (if_b),
        .O_dataValid (dv_b),
        .O_data      (data_b),
        .O_overrun   (ovr_b),
        .O_timeout   (tmo_b),
        .O_frameDone (fd_b)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] exp_tbl [4] = '{16'h0005, 16'h4105, 16'h8205, 16'hC305};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ADC model A: busy one cycle after convst falls, high 20 cycles; db = read*0x100+5.
    bit   stuck_a = 1'b0;
    int   bcnt_a = 0, rdix_a = 0;
    logic pcv_a = 1'b1, prd_a = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            bcnt_a = 0; rdix_a = 0; pcv_a = 1'b1; prd_a = 1'b1;
            if_a.ADC_I_busy = 1'b0;
            if_a.ADC_I_db   = '0;
        end else begin
            if (pcv_a && !if_a.ADC_O_convst_n && !stuck_a) begin
                bcnt_a = 21;
                for (int k = 0; k < 4; k++) qa.push_back(exp_tbl[k]);
            end else if (bcnt_a > 0) begin
                bcnt_a--;
                if_a.ADC_I_busy = (bcnt_a != 0);
            end
            if (if_a.ADC_O_cs_n) rdix_a = 0;
            else if (prd_a && !if_a.ADC_O_rd_n) begin
                if_a.ADC_I_db = 14'(rdix_a * 256 + 5);
                rdix_a++;
            end
            pcv_a = if_a.ADC_O_convst_n;
            prd_a = if_a.ADC_O_rd_n;
        end
    end

    // ADC model B: same behaviour, never stuck.
    int   bcnt_b = 0, rdix_b = 0;
    logic pcv_b = 1'b1, prd_b = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            bcnt_b = 0; rdix_b = 0; pcv_b = 1'b1; prd_b = 1'b1;
            if_b.ADC_I_busy = 1'b0;
            if_b.ADC_I_db   = '0;
        end else begin
            if (pcv_b && !if_b.ADC_O_convst_n) begin
                bcnt_b = 21;
                for (int k = 0; k < 4; k++) qb.push_back(exp_tbl[k]);
            end else if (bcnt_b > 0) begin
                bcnt_b--;
                if_b.ADC_I_busy = (bcnt_b != 0);
            end
            if (if_b.ADC_O_cs_n) rdix_b = 0;
            else if (prd_b && !if_b.ADC_O_rd_n) begin
                if_b.ADC_I_db = 14'(rdix_b * 256 + 5);
                rdix_b++;
            end
            pcv_b = if_b.ADC_O_convst_n;
            prd_b = if_b.ADC_O_rd_n;
        end
    end

    // Monitor A: strobe widths, strobe placement, scoreboard pops, frame completion.
    int   lo_a = 0, hi_a = 0, cvr_a = 0, csr_a = 0, fs_a = 0, nfd_a = 0;
    logic mprd_a = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            lo_a = 0; hi_a = 0; cvr_a = 0; csr_a = 0; fs_a = 0; mprd_a = 1'b1;
        end else begin
            if (!if_a.ADC_O_convst_n) begin
                cvr_a++;
                fs_a = 0;
            end else if (cvr_a > 0) begin
                chk("convst_low_width", cvr_a, 2);
                cvr_a = 0;
            end
            if (!if_a.ADC_O_rd_n) begin
                if (hi_a > 0) begin
                    chk("rd_gap_width", hi_a, 2);
                    hi_a = 0;
                end
                lo_a++;
            end else begin
                if (lo_a > 0) begin
                    chk("rd_low_width", lo_a, 3);
                    lo_a = 0;
                end
                if (!if_a.ADC_O_cs_n) hi_a++;
            end
            if (!if_a.ADC_O_cs_n) csr_a++;
            if (dv_a) begin
                fs_a++;
                chk("dv_in_first_rd_high", {30'd0, mprd_a, if_a.ADC_O_rd_n}, 32'd1);
                chk("strobe_expected_a", qa.size() != 0, 1);
                if (qa.size() != 0) chk("data_a", data_a, qa.pop_front());
            end
            if (fd_a) begin
                nfd_a++;
                chk("frame_strobes_a", fs_a, 4);
                chk("frame_cs_low_cycles", csr_a, 20);
                chk("last_gap_width", hi_a, 2);
                chk("data_hold_a", data_a, 16'hC305);
                hi_a = 0;
                csr_a = 0;
            end
            mprd_a = if_a.ADC_O_rd_n;
        end
    end

    // Monitor B: scoreboard pops and per-frame strobe count.
    int   fs_b = 0, nfd_b = 0, ncv_b = 0, nst_b = 0;
    logic mpcv_b = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            fs_b = 0; mpcv_b = 1'b1;
        end else begin
            if (mpcv_b && !if_b.ADC_O_convst_n) begin
                ncv_b++;
                fs_b = 0;
            end
            if (dv_b) begin
                fs_b++;
                nst_b++;
                chk("strobe_expected_b", qb.size() != 0, 1);
                if (qb.size() != 0) chk("data_b", data_b, qb.pop_front());
            end
            if (fd_b) begin
                nfd_b++;
                chk("frame_strobes_b", fs_b, 4);
            end
            mpcv_b = if_b.ADC_O_convst_n;
        end
    end

    task automatic wait_cv_fall_a(input int limit, output bit ok, output int at);
        int n = 0;
        ok = 1'b0;
        at = 0;
        while (if_a.ADC_O_convst_n !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (if_a.ADC_O_convst_n === 1'b0) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        #1;
    endtask

    task automatic wait_fd_a(input int limit, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (fd_a === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    initial begin
        bit ok;
        int t0, t1, t2, n, m, dvc;
        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_convst_n", if_a.ADC_O_convst_n, 1);
        chk("rst_cs_n", if_a.ADC_O_cs_n, 1);
        chk("rst_rd_n", if_a.ADC_O_rd_n, 1);
        chk("rst_dv", dv_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_overrun", ovr_a, 0);
        chk("rst_timeout", tmo_a, 0);
        chk("rst_framedone", fd_a, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        en_a = 1'b1;

        // Periodic frames 400 cycles apart, each with the four tagged words.
        wait_cv_fall_a(1000, ok, t0);
        chk("first_convst", ok, 1);
        wait_cv_fall_a(1000, ok, t1);
        chk("frame_period_1", t1 - t0, 400);
        wait_cv_fall_a(1000, ok, t2);
        chk("frame_period_2", t2 - t1, 400);
        wait_fd_a(1000, ok);
        chk("frame_done_seen", ok, 1);
        chk("frames_completed", nfd_a, 3);
        chk("queue_a_drained", qa.size(), 0);
        chk("no_overrun_a", ovr_a, 0);
        chk("no_timeout_a", tmo_a, 0);

        // Busy never rises: timeout 64 cycles into WAIT_BHI, then a clean retry.
        stuck_a = 1'b1;
        wait_cv_fall_a(1000, ok, t0);
        chk("stuck_convst", ok, 1);
        n = 0;
        dvc = 0;
        while (tmo_a !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (dv_a) dvc++;
        end
        #1;
        chk("timeout_latency", n, 66);
        chk("timeout_no_strobes", dvc, 0);
        chk("timeout_convst_n", if_a.ADC_O_convst_n, 1);
        chk("timeout_cs_n", if_a.ADC_O_cs_n, 1);
        chk("timeout_rd_n", if_a.ADC_O_rd_n, 1);
        stuck_a = 1'b0;
        wait_fd_a(1000, ok);
        chk("retry_frame_done", ok, 1);
        chk("retry_frames", nfd_a, 4);
        chk("timeout_sticky", tmo_a, 1);

        // Reset during the channel-2 read aborts the frame.
        wait_cv_fall_a(1000, ok, t0);
        chk("pre_reset_convst", ok, 1);
        n = 0;
        dvc = 0;
        while (dvc < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (dv_a) dvc++;
        end
        chk("two_strobes_before_reset", dvc, 2);
        n = 0;
        while (if_a.ADC_O_rd_n !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ch2_read_reached", if_a.ADC_O_rd_n, 0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_convst_n", if_a.ADC_O_convst_n, 1);
        chk("midrst_cs_n", if_a.ADC_O_cs_n, 1);
        chk("midrst_rd_n", if_a.ADC_O_rd_n, 1);
        chk("midrst_dv", dv_a, 0);
        chk("midrst_data", data_a, 0);
        chk("midrst_timeout", tmo_a, 0);
        chk("midrst_framedone", fd_a, 0);
        qa.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        dvc = 0;
        while (if_a.ADC_O_convst_n !== 1'b0 && n < 600) begin
            @(negedge clk);
            n++;
            if (dv_a) dvc++;
        end
        #1;
        chk("post_reset_first_convst", n, 401);
        chk("post_reset_no_strobes", dvc, 0);
        wait_fd_a(200, ok);
        chk("post_reset_frame_done", ok, 1);

        // Enable dropped while waiting for busy low: frame still completes, then silence.
        wait_cv_fall_a(1000, ok, t0);
        chk("pre_disable_convst", ok, 1);
        n = 0;
        while (if_a.ADC_I_busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        #1 en_a = 1'b0;
        wait_fd_a(200, ok);
        chk("disable_frame_done", ok, 1);
        m = 0;
        repeat (1200) begin
            @(negedge clk);
            if (if_a.ADC_O_convst_n === 1'b0) m++;
        end
        #1;
        chk("no_convst_after_disable", m, 0);
        chk("queue_a_empty_end", qa.size(), 0);

        // Fast sample rate: second tick lands mid-frame and is flagged as overrun.
        @(posedge clk);
        #1 en_b = 1'b1;
        n = 0;
        while (if_b.ADC_O_convst_n !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("b_first_convst", if_b.ADC_O_convst_n, 0);
        chk("b_no_overrun_yet", ovr_b, 0);
        m = 0;
        while (ovr_b !== 1'b1 && m < 100) begin
            @(negedge clk);
            m++;
        end
        #1;
        chk("b_overrun_latency", m, 30);
        repeat (200) @(negedge clk);
        #1 en_b = 1'b0;
        repeat (150) @(negedge clk);
        #1;
        chk("b_overrun_sticky", ovr_b, 1);
        chk("b_frames_ge2", ncv_b >= 2, 1);
        chk("b_all_frames_done", nfd_b, ncv_b);
        chk("b_total_strobes", nst_b, 4 * ncv_b);
        chk("queue_b_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Upstream feeder for the dual-bank acquisition buffer. It paces a 4-channel simultaneous-sampling parallel ADC: periodic conversion start, busy handshake, then sequential channel reads. Each conversion result is emitted as a one-cycle O_dataValid strobe with a tagged 16-bit word, which drives the buffer's ADC_I_dataValid and ADC_I_data inputs directly.

Parameters:
NUM_CH, 4, channels read per conversion frame (1..4)
SAMPLE_DIV, 400, ADC_I_clk cycles per sample period (>= frame length + 8)
CONVST_LEN, 2, cycles ADC_O_convst_n is held low
RD_LOW, 3, cycles ADC_O_rd_n is held low per channel read
RD_GAP, 2, cycles ADC_O_rd_n is held high between reads
BUSY_TIMEOUT, 64, maximum cycles spent waiting on each busy edge

Ports:
ADC_I_clk  input  1  sole clock
I_rst_n  input  1  reset, synchronous, active-low
I_enable  input  1  1 = run periodic sampling
ADC_O_convst_n  output  1  conversion start to ADC, active-low
ADC_I_busy  input  1  ADC busy, asynchronous to ADC_I_clk
ADC_O_cs_n  output  1  ADC chip select, active-low
ADC_O_rd_n  output  1  ADC read strobe, active-low
ADC_I_db  input  14  ADC parallel data, two's complement
O_dataValid  output  1  one-cycle strobe: O_data is valid
O_data  output  16  {channel[1:0], sample[13:0]}
O_overrun  output  1  sticky: sample tick missed
O_timeout  output  1  sticky: busy handshake timed out
O_frameDone  output  1  one-cycle pulse after the last channel of a frame

Behaviour:
- Reset (I_rst_n=0 at a clock edge) drives convst_n=1, cs_n=1, rd_n=1, O_dataValid=0, O_data=0, O_overrun=0, O_timeout=0, O_frameDone=0. It also clears the tick counter and the busy synchronizer and puts the FSM in IDLE. Reset mid-frame aborts immediately, with no further strobes.
- ADC_I_busy passes through a 2-FF synchronizer. All FSM decisions use the synchronized value, so edge recognition lags the pin by 2 cycles.
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps while I_enable=1. It is held at 0 while I_enable=0. A tick is asserted in the cycle the counter equals SAMPLE_DIV-1.
- FSM states:
  - IDLE: waits for a tick, then goes to CONVST.
  - CONVST: convst_n=0 for CONVST_LEN cycles, then WAIT_BHI.
  - WAIT_BHI: waits for busy_sync=1, then WAIT_BLO.
  - WAIT_BLO: waits for busy_sync=0. Then cs_n is driven 0, the channel index is reset to 0, and the FSM goes to RD_LO.
  - RD_LO: rd_n=0 for RD_LOW cycles. ADC_I_db is captured on the last rd_n-low cycle.
  - RD_HI: rd_n=1. O_dataValid=1 for exactly one cycle, in the first RD_HI cycle, with O_data = {ch, captured}. The FSM stays in RD_HI for RD_GAP cycles.
  - Next channel: if ch < NUM_CH-1, increment ch and return to RD_LO. Otherwise set cs_n=1, pulse O_frameDone in the cycle after the last RD_HI, and return to IDLE.
- Timeouts: WAIT_BHI and WAIT_BLO each have a BUSY_TIMEOUT counter. On expiry, O_timeout is set (sticky), convst_n, cs_n and rd_n go high, no data is emitted for the frame, and the FSM goes to IDLE. The next tick retries.
- Overrun: a tick arriving while the FSM is not in IDLE is dropped and O_overrun is set (sticky). A tick in the same cycle as the IDLE-entry transition counts as not-idle, so it is an overrun.
- I_enable deasserted mid-frame: the current frame completes normally and no new tick follows.
- Sticky flags clear only on reset.
- O_data holds its last value between strobes.
- Channel tag: for NUM_CH<4, unused tag values never appear.
- Frame length from WAIT_BLO exit to O_frameDone = NUM_CH*(RD_LOW+RD_GAP)+1 cycles.

Test Plan:
1. Reset then enable, SAMPLE_DIV=400, ADC model with busy 1 cycle after convst_n falls and busy high 20 cycles, db=ch*0x100+5 -> per frame: exactly 4 O_dataValid strobes with O_data=0x0005, 0x4105, 0x8205, 0xC305; frames 400 cycles apart; cs_n low only during reads.
2. Cycle check of one frame -> convst_n low exactly 2 cycles; rd_n low 3 cycles and high 2 cycles between reads; O_dataValid 1 cycle wide in the first rd_n-high cycle; O_frameDone 1 cycle after the last gap.
3. Busy held at 0 forever -> O_timeout=1 after 64 cycles in WAIT_BHI, no O_dataValid, convst_n/cs_n high; busy model restored -> the next tick produces a normal 4-strobe frame, and O_timeout stays 1.
4. SAMPLE_DIV=30 with busy high 20 cycles -> O_overrun=1 on the first tick during a frame; every frame already started still emits all 4 strobes.
5. I_rst_n pulsed low during RD_LO of channel 2 -> on the next edge all outputs are at reset values, there are no further strobes, and the FSM restarts from IDLE after release with enable.
6. I_enable dropped during WAIT_BLO -> the frame completes with 4 strobes and O_frameDone; no further convst_n pulses for over 1000 cycles.
